hazard_forward_unit: RTL and testbench

//  Stall/forward controller for the 5-stage MIPS pipeline; successor to the fixed-opcode forwarding decoder.

---
 rtl/hazard_forward_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: RAW stall / forward-select controller for the 5-stage MIPS pipeline.
// Hazards are resolved from per-instruction Tuse/Tnew/dest fields supplied by the D-stage
// decoder. Destination and Tnew of the E, M and W stages are tracked internally.
// Optional HI/LO mult/div busy tracking is compiled in when HFU_MD_UNIT_EN is defined;
// without it md_busy is tied low and the md inputs are ignored.
module hazard_forward_unit #(
   parameter int unsigned RA_W     = 5,
   parameter int unsigned T_W      = 2,
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            d_valid,
   input  logic [RA_W-1:0] d_rs,
   input  logic [RA_W-1:0] d_rt,
   input  logic [T_W-1:0]  d_tuse_rs,
   input  logic [T_W-1:0]  d_tuse_rt,
   input  logic [RA_W-1:0] d_dest,
   input  logic [T_W-1:0]  d_tnew,
   input  logic            d_is_md,
   input  logic            e_md_start,
   input  logic            e_md_is_div,
   output logic            stall,
   output logic [1:0]      fwd_d_rs,
   output logic [1:0]      fwd_d_rt,
   output logic [1:0]      fwd_e_rs,
   output logic [1:0]      fwd_e_rt,
   output logic            fwd_m_rt,
   output logic            md_busy
);

   localparam int unsigned CNT_W =
      $clog2(((MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC) + 1);

   // Per-stage tracking; W only needs its destination since its result is always ready.
   logic [RA_W-1:0] eDest, eRs, eRt;
   logic [T_W-1:0]  eTnew;
   logic [RA_W-1:0] mDest, mRt;
   logic [T_W-1:0]  mTnew;
   logic [RA_W-1:0] wDest;
   logic            mdStall;

   function automatic logic [T_W-1:0] satDec(input logic [T_W-1:0] t);
      return (t == '0) ? t : t - T_W'(1);
   endfunction

   // Operand hazard that forwarding cannot cover: producer result arrives after it is needed.
   function automatic logic opStall(
      input logic [RA_W-1:0] r,   input logic [T_W-1:0] tuse,
      input logic [RA_W-1:0] eD,  input logic [T_W-1:0] eT,
      input logic [RA_W-1:0] mD,  input logic [T_W-1:0] mT
   );
      return (tuse != '1) && (r != '0) &&
             (((eD == r) && (eT > tuse)) || ((mD == r) && (mT > tuse)));
   endfunction

   // D-operand select: youngest matching stage wins; if it is not ready the select stays 0.
   function automatic logic [1:0] dSel(
      input logic [RA_W-1:0] r,
      input logic [RA_W-1:0] eD, input logic [T_W-1:0] eT,
      input logic [RA_W-1:0] mD, input logic [T_W-1:0] mT,
      input logic [RA_W-1:0] wD
   );
      if (r == '0) return 2'd0;
      if (eD == r) return (eT == '0) ? 2'd1 : 2'd0;
      if (mD == r) return (mT == '0) ? 2'd2 : 2'd0;
      if (wD == r) return 2'd3;
      return 2'd0;
   endfunction

   // E/M-operand select against M then W, same youngest-match masking.
   function automatic logic [1:0] eSel(
      input logic [RA_W-1:0] r,
      input logic [RA_W-1:0] mD, input logic [T_W-1:0] mT,
      input logic [RA_W-1:0] wD
   );
      if (r == '0) return 2'd0;
      if (mD == r) return (mT == '0) ? 2'd2 : 2'd0;
      if (wD == r) return 2'd3;
      return 2'd0;
   endfunction

   // Advance the tracked pipeline; a stalled or invalid D instruction becomes a bubble in E.
   always_ff @(posedge clk) begin
      if (reset) begin
         eDest <= '0;
         eTnew <= '0;
         eRs   <= '0;
         eRt   <= '0;
         mDest <= '0;
         mTnew <= '0;
         mRt   <= '0;
         wDest <= '0;
      end else begin
         wDest <= mDest;
         mDest <= eDest;
         mTnew <= satDec(eTnew);
         mRt   <= eRt;
         if (stall || !d_valid) begin
            eDest <= '0;
            eTnew <= '0;
            eRs   <= '0;
            eRt   <= '0;
         end else begin
            eDest <= d_dest;
            eTnew <= d_tnew;
            eRs   <= d_rs;
            eRt   <= d_rt;
         end
      end
   end

`ifdef HFU_MD_UNIT_EN
   logic [CNT_W-1:0] mdCnt;

   // Busy countdown; a start while already counting is ignored rather than reloading.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdCnt <= '0;
      end else if (e_md_start && (mdCnt == '0)) begin
         mdCnt <= e_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (mdCnt != '0) begin
         mdCnt <= mdCnt - CNT_W'(1);
      end
   end

   assign md_busy = e_md_start | (mdCnt != '0);
   assign mdStall = d_valid & d_is_md & md_busy;
`else
   logic [CNT_W-1:0] unusedMdCfg;
   logic             unusedMdIn;

   assign unusedMdCfg = CNT_W'(MULT_CYC) ^ CNT_W'(DIV_CYC);
   assign unusedMdIn  = d_is_md ^ e_md_start ^ e_md_is_div;
   assign md_busy     = 1'b0;
   assign mdStall     = 1'b0;
`endif

   // Stall and forward selects, purely from tracked state and the current D fields.
   always_comb begin
      stall    = mdStall |
                 (d_valid & (opStall(d_rs, d_tuse_rs, eDest, eTnew, mDest, mTnew) |
                             opStall(d_rt, d_tuse_rt, eDest, eTnew, mDest, mTnew)));
      fwd_d_rs = dSel(d_rs, eDest, eTnew, mDest, mTnew, wDest);
      fwd_d_rt = dSel(d_rt, eDest, eTnew, mDest, mTnew, wDest);
      fwd_e_rs = eSel(eRs, mDest, mTnew, wDest);
      fwd_e_rt = eSel(eRt, mDest, mTnew, wDest);
      fwd_m_rt = (mRt != '0) && (mRt == wDest);
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an age-based behavioural model of the pipeline.
module tb_hazard_forward_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       dValid;
   logic [4:0] dRs, dRt, dDest;
   logic [1:0] dTuseRs, dTuseRt, dTnew;
   logic       dIsMd, eMdStart, eMdIsDiv;
   logic       stall, fwdMRt, mdBusy;
   logic [1:0] fwdDRs, fwdDRt, fwdERs, fwdERt;

   int checks = 0;
   int errors = 0;
   bit modelOn = 0;

   hazard_forward_unit #(.RA_W(5), .T_W(2), .MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
      .clk(clk), .reset(reset), .d_valid(dValid), .d_rs(dRs), .d_rt(dRt),
      .d_tuse_rs(dTuseRs), .d_tuse_rt(dTuseRt), .d_dest(dDest), .d_tnew(dTnew),
      .d_is_md(dIsMd), .e_md_start(eMdStart), .e_md_is_div(eMdIsDiv),
      .stall(stall), .fwd_d_rs(fwdDRs), .fwd_d_rt(fwdDRt), .fwd_e_rs(fwdERs),
      .fwd_e_rt(fwdERt), .fwd_m_rt(fwdMRt), .md_busy(mdBusy)
   );

   always #5 clk = ~clk;

   // Model: ent[k] is the instruction k cycles past D (0=E, 1=M, 2=W) with its Tnew at entry.
   typedef struct {int dest; int tnew0; int rs; int rt;} ent_t;
   ent_t ent[3];
   int   cyc = 0;
   int   busyEnd = 0;

   function automatic int remT(int k);
      if (k == 2) return 0;
      return (ent[k].tnew0 > k) ? ent[k].tnew0 - k : 0;
   endfunction

   function automatic bit opHaz(int r, int tuse);
      if (tuse == 3 || r == 0) return 0;
      for (int k = 0; k < 2; k++)
         if (ent[k].dest == r && remT(k) > tuse) return 1;
      return 0;
   endfunction

   function automatic int selFrom(int r, int firstStage);
      if (r == 0) return 0;
      for (int k = firstStage; k < 3; k++)
         if (ent[k].dest == r) return (remT(k) == 0) ? k + 1 : 0;
      return 0;
   endfunction

   function automatic bit expBusy();
`ifdef HFU_MD_UNIT_EN
      return eMdStart || (cyc < busyEnd);
`else
      return 0;
`endif
   endfunction

   function automatic bit expStall();
      bit s;
      s = dValid && (opHaz(int'(dRs), int'(dTuseRs)) || opHaz(int'(dRt), int'(dTuseRt)));
      return s || (dValid && dIsMd && expBusy());
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (modelOn) begin
         cmp("stall", int'(stall), int'(expStall()));
         cmp("fwd_d_rs", int'(fwdDRs), selFrom(int'(dRs), 0));
         cmp("fwd_d_rt", int'(fwdDRt), selFrom(int'(dRt), 0));
         cmp("fwd_e_rs", int'(fwdERs), selFrom(ent[0].rs, 1));
         cmp("fwd_e_rt", int'(fwdERt), selFrom(ent[0].rt, 1));
         cmp("fwd_m_rt", int'(fwdMRt), (ent[1].rt != 0 && ent[2].dest == ent[1].rt) ? 1 : 0);
         cmp("md_busy", int'(mdBusy), int'(expBusy()));
      end
   end

   task automatic tick();
      bit s;
      s = expStall();
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < 3; k++) ent[k] = '{0, 0, 0, 0};
         busyEnd = 0;
      end else begin
`ifdef HFU_MD_UNIT_EN
         if (eMdStart && !(cyc < busyEnd))
            busyEnd = cyc + (eMdIsDiv ? DIV_N : MULT_N) + 1;
`endif
         ent[2] = ent[1];
         ent[1] = ent[0];
         if (s || !dValid) ent[0] = '{0, 0, 0, 0};
         else ent[0] = '{int'(dDest), int'(dTnew), int'(dRs), int'(dRt)};
      end
      cyc++;
      #1;
   endtask

   task automatic setD(input bit v, input int rs, input int rt, input int turs,
                       input int turt, input int dest, input int tnew, input bit md);
      dValid = v; dRs = 5'(rs); dRt = 5'(rt); dTuseRs = 2'(turs); dTuseRt = 2'(turt);
      dDest = 5'(dest); dTnew = 2'(tnew); dIsMd = md;
   endtask

   task automatic bubbleD();
      setD(0, 0, 0, 3, 3, 0, 0, 0);
   endtask

   task automatic flush();
      bubbleD();
      repeat (3) tick();
   endtask

   int n;

   initial begin
      for (int k = 0; k < 3; k++) ent[k] = '{0, 0, 0, 0};
      reset = 1'b1; eMdStart = 1'b0; eMdIsDiv = 1'b0;
      bubbleD();
      tick();
      modelOn = 1;
      tick();
      reset = 1'b0;

      @(negedge clk);
      cmp("rst_stall", int'(stall), 0);
      cmp("rst_fwd", int'({fwdDRs, fwdDRt, fwdERs, fwdERt, fwdMRt}), 0);
      cmp("rst_md_busy", int'(mdBusy), 0);

      // lw $1 (tnew 2) then addu rs=$1 (tuse 1)
      setD(1, 5, 3, 1, 3, 1, 2, 0);
      tick();
      setD(1, 1, 2, 1, 1, 4, 1, 0);
      @(negedge clk); cmp("lw_use_stall", int'(stall), 1);
      tick();
      @(negedge clk); cmp("lw_use_release", int'(stall), 0);
      cmp("lw_use_fwd_d_rs", int'(fwdDRs), 0);
      tick();
      bubbleD();
      @(negedge clk); cmp("lw_use_fwd_e_rs", int'(fwdERs), 3);
      cmp("lw_use_fwd_e_rt", int'(fwdERt), 0);

      // ori $2 in M, beq rs=$2 tuse 0
      flush();
      setD(1, 0, 0, 3, 3, 2, 1, 0);
      tick();
      bubbleD();
      tick();
      setD(1, 2, 0, 0, 3, 0, 0, 0);
      @(negedge clk); cmp("beq_stall", int'(stall), 0);
      cmp("beq_fwd_d_rs", int'(fwdDRs), 2);

      // jal in E, jr $31
      flush();
      setD(1, 0, 0, 3, 3, 31, 0, 0);
      tick();
      setD(1, 31, 0, 0, 3, 0, 0, 0);
      @(negedge clk); cmp("jr_stall", int'(stall), 0);
      cmp("jr_fwd_d_rs", int'(fwdDRs), 1);
      flush();
      setD(1, 0, 0, 3, 3, 0, 0, 0);
      tick();
      setD(1, 31, 0, 0, 3, 0, 0, 0);
      @(negedge clk); cmp("jr_nodest_fwd_d_rs", int'(fwdDRs), 0);

      // lw $3 then addu $3 then consumer of rt=$3
      flush();
      setD(1, 0, 0, 3, 3, 3, 2, 0);
      tick();
      setD(1, 0, 0, 3, 3, 3, 1, 0);
      tick();
      setD(1, 0, 3, 3, 2, 0, 0, 0);
      @(negedge clk); cmp("mprio_stall", int'(stall), 0);
      cmp("mprio_fwd_d_rt", int'(fwdDRt), 0);
      tick();
      bubbleD();
      @(negedge clk); cmp("mprio_fwd_e_rt", int'(fwdERt), 2);
      tick();
      @(negedge clk); cmp("store_fwd_m_rt", int'(fwdMRt), 1);

`ifdef HFU_MD_UNIT_EN
      // div start with mflo waiting in D
      flush();
      eMdStart = 1'b1; eMdIsDiv = 1'b1;
      setD(1, 0, 0, 3, 3, 0, 0, 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         tick();
         eMdStart = 1'b0;
      end
      eMdStart = 1'b0;
      cmp("div_stall_cycles", n, 11);
      cmp("div_busy_release", int'(mdBusy), 0);
`endif

      // reset with md counter at 7 and lw in E
      flush();
      eMdStart = 1'b1; eMdIsDiv = 1'b1;
      tick();
      eMdStart = 1'b0;
      tick();
      tick();
      setD(1, 5, 0, 1, 3, 1, 2, 0);
      tick();
      setD(1, 1, 0, 1, 3, 4, 1, 0);
      @(negedge clk); cmp("pre_reset_stall", int'(stall), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk); cmp("post_reset_stall", int'(stall), 0);
      cmp("post_reset_md_busy", int'(mdBusy), 0);
      cmp("post_reset_fwd", int'({fwdDRs, fwdDRt, fwdERs, fwdERt, fwdMRt}), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 249) == 0);
         setD($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 4) == 0);
         eMdStart = ($urandom_range(0, 19) == 0);
         eMdIsDiv = $urandom_range(0, 1) == 1;
         tick();
      end
      reset = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
